// File: rtl/seq_shift_pkg.sv
// ============================================================================
// Module   : seq_shift_pkg
// Brief    : Shared operation and state encodings for the sequential shifter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_shift_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Brief    : Combinational single-position shift/rotate with shifted-out bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_step
    import seq_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_d,
    input  op_t          i_op,
    output logic [N-1:0] o_d_next,
    output logic         o_bit_out
);

    always_comb begin
        o_d_next  = {1'b0, i_d[N-1:1]};
        o_bit_out = i_d[0];
        case (i_op)
            OP_SRL: begin
                o_d_next  = {1'b0, i_d[N-1:1]};
                o_bit_out = i_d[0];
            end
            OP_SLL: begin
                o_d_next  = {i_d[N-2:0], 1'b0};
                o_bit_out = i_d[N-1];
            end
            OP_SRA: begin
                o_d_next  = {i_d[N-1], i_d[N-1:1]};
                o_bit_out = i_d[0];
            end
            OP_ROR: begin
                o_d_next  = {i_d[0], i_d[N-1:1]};
                o_bit_out = i_d[0];
            end
            default: begin
                o_d_next  = {1'b0, i_d[N-1:1]};
                o_bit_out = i_d[0];
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// ============================================================================
// Module   : seq_shift_unit
// Brief    : Multi-cycle shift/rotate unit, one bit position per clock, with
//            valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int N    = 8,
    parameter int SA_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [SA_W-1:0] shift_amount,
    input  logic [1:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out,
    output logic            carry
);

    localparam logic [SA_W-1:0] c_count_zero = '0;
    localparam logic [SA_W-1:0] c_count_one  = {{(SA_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [N-1:0]    r_data;
    logic [N-1:0]    r_out;
    op_t             r_op;
    logic [SA_W-1:0] r_count;
    logic            r_carry;

    logic [N-1:0]    w_d_next;
    logic            w_bit_out;

    shift_step #(
        .N (N)
    ) u_shift_step (
        .i_d       (r_data),
        .i_op      (r_op),
        .o_d_next  (w_d_next),
        .o_bit_out (w_bit_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_out   <= '0;
            r_op    <= OP_SRL;
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= a;
                        r_op    <= op_t'(op);
                        r_count <= shift_amount;
                        r_carry <= 1'b0;
                        if (shift_amount == c_count_zero) begin
                            r_out   <= a;
                            r_state <= DONE;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data  <= w_d_next;
                    r_carry <= w_bit_out;
                    r_count <= r_count - c_count_one;
                    // The result register only moves on the final step, so a
                    // partially shifted value never reaches the output.
                    if (r_count == c_count_one) begin
                        r_out   <= w_d_next;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign carry     = r_carry;

endmodule

`default_nettype wire
